// File: rtl/acp_mm2s_engine.sv
// ---------------------------------------------------------------------------
// acp_mm2s_engine
//   Memory-to-stream read engine for the ACP port. Accepts one
//   datamover-format command, splits it into INCR bursts that never cross a
//   4 KiB page and never exceed C_MAX_BURST beats, and forwards read data
//   unmodified to an AXI-Stream master. A one-byte completion status is
//   emitted per command.
//
// Ports
//   clk, aresetn             clock, asynchronous active-low reset
//   S_AXIS_CMD_*             72-bit command stream (BTT, TYPE, EOF, SADDR, TAG)
//   M_AXIS_STS_*             8-bit status stream {OKAY,SLVERR,DECERR,INTERR,TAG}
//   M_AXI_AR*                read address channel (one burst in flight)
//   M_AXI_R*                 read data channel
//   M_AXIS_T*                64-bit output stream, combinational from R
// ---------------------------------------------------------------------------
module acp_mm2s_engine #(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [2:0] C_PROT             = 3'b010,
  parameter logic [3:0] C_CACHE            = 4'b1111,
  parameter int         C_MAX_BURST        = 16
) (
  input  logic                          clk,
  input  logic                          aresetn,
  // command
  input  logic                          S_AXIS_CMD_TVALID,
  output logic                          S_AXIS_CMD_TREADY,
  input  logic [71:0]                   S_AXIS_CMD_TDATA,
  // status
  output logic                          M_AXIS_STS_TVALID,
  input  logic                          M_AXIS_STS_TREADY,
  output logic [7:0]                    M_AXIS_STS_TDATA,
  // read address
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  // read data
  input  logic [63:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  // output stream
  output logic [63:0]                   M_AXIS_TDATA,
  output logic [7:0]                    M_AXIS_TKEEP,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, STS} state_t;

  state_t        state;
  logic [AW-1:0] addr;      // start address of the current/next burst
  logic [19:0]   rem;       // beats still owed for this command
  logic [7:0]    arlen_q;
  logic [7:0]    bcnt;      // beats accepted within the current burst
  logic [3:0]    tag;
  logic          eof;
  logic          interr, slverr, decerr;
  logic          cmd_rdy, arvalid_q, sts_vld;

  // Beats for the next burst: clipped by remaining count, the burst cap and
  // the distance to the next 4 KiB page (address is always 8-byte aligned).
  function automatic logic [8:0] burst_beats(input logic [AW-1:0] a,
                                             input logic [19:0]   r);
    logic [19:0] b, to4k;
    b    = r;
    if (b > 20'(C_MAX_BURST)) b = 20'(C_MAX_BURST);
    to4k = 20'd512 - {11'd0, a[11:3]};
    if (b > to4k) b = to4k;
    return 9'(b);
  endfunction

  // ---- command decode ----
  logic [22:0]   cmd_btt;
  logic          cmd_type, cmd_eof, cmd_bad;
  logic [31:0]   cmd_saddr;
  logic [AW-1:0] cmd_addr;
  logic [19:0]   cmd_beats;
  logic [8:0]    first_len;

  assign cmd_btt   = S_AXIS_CMD_TDATA[22:0];
  assign cmd_type  = S_AXIS_CMD_TDATA[23];
  assign cmd_eof   = S_AXIS_CMD_TDATA[30];
  assign cmd_saddr = S_AXIS_CMD_TDATA[63:32];
  assign cmd_addr  = AW'(cmd_saddr);
  assign cmd_beats = cmd_btt[22:3];
  assign cmd_bad   = (cmd_btt == '0) || (cmd_btt[2:0] != 3'd0) ||
                     (cmd_saddr[2:0] != 3'd0) || !cmd_type;
  assign first_len = burst_beats(cmd_addr, cmd_beats);

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31],
                             S_AXIS_CMD_TDATA[29:24]};

  // ---- data phase bookkeeping ----
  logic          in_data, beat, burst_end, cmd_last;
  logic [8:0]    blen, nxt_len;
  logic [AW-1:0] nxt_addr;
  logic [19:0]   nxt_rem;

  assign in_data   = (state == DATA);
  assign beat      = in_data && M_AXI_RVALID && M_AXIS_TREADY;
  assign burst_end = (bcnt == arlen_q);
  assign blen      = {1'b0, arlen_q} + 9'd1;
  assign nxt_addr  = addr + AW'({blen, 3'b000});
  assign nxt_rem   = rem - {11'd0, blen};
  assign nxt_len   = burst_beats(nxt_addr, nxt_rem);
  // final beat of the whole command, by the engine's own count
  assign cmd_last  = burst_end && (rem == {11'd0, blen});

  // ---- control FSM ----
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cmd_rdy   <= 1'b0;
      arvalid_q <= 1'b0;
      sts_vld   <= 1'b0;
      addr      <= '0;
      rem       <= '0;
      arlen_q   <= '0;
      bcnt      <= '0;
      tag       <= '0;
      eof       <= 1'b0;
      interr    <= 1'b0;
      slverr    <= 1'b0;
      decerr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_rdy <= 1'b1;
          if (S_AXIS_CMD_TVALID && cmd_rdy) begin
            cmd_rdy <= 1'b0;
            tag     <= S_AXIS_CMD_TDATA[67:64];
            eof     <= cmd_eof;
            addr    <= cmd_addr;
            rem     <= cmd_beats;
            bcnt    <= '0;
            slverr  <= 1'b0;
            decerr  <= 1'b0;
            arlen_q <= 8'(first_len - 9'd1);
            if (cmd_bad) begin
              interr  <= 1'b1;
              sts_vld <= 1'b1;
              state   <= STS;
            end else begin
              interr    <= 1'b0;
              arvalid_q <= 1'b1;
              state     <= ADDR;
            end
          end
        end
        ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            bcnt      <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (M_AXI_RRESP == 2'b10) slverr <= 1'b1;
            if (M_AXI_RRESP == 2'b11) decerr <= 1'b1;
            // slave's RLAST disagreeing with our count is flagged, not obeyed
            if (M_AXI_RLAST != burst_end) interr <= 1'b1;
            if (burst_end) begin
              addr <= nxt_addr;
              rem  <= nxt_rem;
              bcnt <= '0;
              if (nxt_rem == '0) begin
                sts_vld <= 1'b1;
                state   <= STS;
              end else begin
                arlen_q   <= 8'(nxt_len - 9'd1);
                arvalid_q <= 1'b1;
                state     <= ADDR;
              end
            end else begin
              bcnt <= bcnt + 8'd1;
            end
          end
        end
        STS: begin
          if (M_AXIS_STS_TREADY) begin
            sts_vld <= 1'b0;
            cmd_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- outputs ----
  assign S_AXIS_CMD_TREADY = cmd_rdy;

  assign M_AXIS_STS_TVALID = sts_vld;
  assign M_AXIS_STS_TDATA  = {~(slverr | decerr | interr), slverr, decerr,
                              interr, tag};

  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARPROT  = C_PROT;
  assign M_AXI_ARCACHE = C_CACHE;
  assign M_AXI_ARVALID = arvalid_q;

  // zero-latency pass-through; gated by state so reset kills it at once
  assign M_AXI_RREADY  = in_data && M_AXIS_TREADY;
  assign M_AXIS_TVALID = in_data && M_AXI_RVALID;
  assign M_AXIS_TDATA  = M_AXI_RDATA;
  assign M_AXIS_TKEEP  = 8'hFF;
  assign M_AXIS_TLAST  = in_data && M_AXI_RVALID && eof && cmd_last;

endmodule

// File: doc/acp_mm2s_engine.md
ACP_MM2S_ENGINE -- requirements
Module: acp_mm2s_engine

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, meaning ACP address width.
REQ-002 SHALL have parameter C_PROT, default 3'b010, meaning value driven on M_AXI_ARPROT.
REQ-003 SHALL have parameter C_CACHE, default 4'b1111, meaning value driven on M_AXI_ARCACHE (coherent ACP access).
REQ-004 SHALL have parameter C_MAX_BURST, default 16, meaning maximum beats per AXI read burst.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock
- aresetn  in  1  asynchronous active-low reset
- S_AXIS_CMD_TVALID / TREADY / TDATA  in/out/in  1/1/72  datamover-format command
- M_AXIS_STS_TVALID / TREADY / TDATA  out/in/out  1/1/8  completion status
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  burst address
- M_AXI_ARLEN / ARSIZE / ARBURST / ARPROT / ARCACHE  out  8/3/2/3/4  burst attributes
- M_AXI_ARVALID / ARREADY  out/in  1/1  address handshake
- M_AXI_RDATA / RRESP / RLAST / RVALID / RREADY  in/in/in/in/out  64/2/1/1/1  read data
- M_AXIS_TDATA / TKEEP / TLAST / TVALID / TREADY  out/out/out/out/in  64/8/1/1/1  output stream

Function
REQ-007 Command fields SHALL be: [22:0] BTT, [23] TYPE (must be 1 = INCR), [30] EOF, [63:32] SADDR, [67:64] TAG; all other bits ignored.
REQ-008 Status byte SHALL be: [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY; OKAY = 1 only when bits 6:4 are all 0.
REQ-009 The state machine SHALL have states IDLE, ADDR, DATA, STS; reset state IDLE.
REQ-010 S_AXIS_CMD_TREADY SHALL be 1 only in IDLE; a command handshake latches BTT, SADDR, TAG, EOF and clears the error flags.
REQ-011 A command with BTT=0, BTT[2:0]!=0, SADDR[2:0]!=0 or TYPE=0 SHALL go directly to STS with INTERR=1 and SHALL issue no AXI transaction.
REQ-012 A valid command SHALL go to ADDR, with M_AXI_ARVALID=1 in the cycle after the command handshake.
REQ-013 Each burst length SHALL be min(remaining beats, C_MAX_BURST, beats to the next 4 KiB boundary); ARLEN = length-1, ARSIZE=3'b011, ARBURST=2'b01.
REQ-014 ARADDR and ARLEN SHALL stay stable while ARVALID=1 and ARREADY=0; the AR handshake moves the FSM to DATA.
REQ-015 Only one burst SHALL be outstanding at a time.
REQ-016 In DATA, M_AXIS_TVALID SHALL equal M_AXI_RVALID and M_AXI_RREADY SHALL equal M_AXIS_TREADY; TDATA = RDATA; TKEEP = 8'hFF.
REQ-017 The path in REQ-016 SHALL be combinational pass-through, with zero added latency.
REQ-018 M_AXIS_TLAST SHALL be 1 only on the final beat of the command and only when EOF=1.
REQ-019 On each accepted beat, RRESP=2'b10 SHALL set SLVERR and RRESP=2'b11 SHALL set DECERR (sticky per command); the transfer continues to completion.
REQ-020 An accepted beat with RLAST=1 SHALL advance the address by the burst byte count and decrement the remaining count, then go to ADDR, or to STS if none remain.
REQ-021 A beat-count/RLAST mismatch SHALL set INTERR; the engine follows its own beat count.
REQ-022 In STS, M_AXIS_STS_TVALID SHALL be 1 with stable TDATA until STS_TREADY; on the handshake the FSM returns to IDLE.
REQ-023 A new command SHALL NOT be accepted before the status handshake.
REQ-024 Remaining count SHALL be 20 bits (BTT>>3); address arithmetic SHALL be C_M_AXI_ADDR_WIDTH bits and wrap modulo 2^width.

Reset
REQ-025 Assertion of aresetn=0 SHALL immediately (asynchronously) force IDLE and set ARVALID, RREADY, M_AXIS_TVALID, TLAST and STS_TVALID to 0.
REQ-026 During reset, S_AXIS_CMD_TREADY SHALL be 0 and all latched fields SHALL be 0.
REQ-027 After reset, CMD_TREADY SHALL be 1 from the first clock edge with aresetn=1.
REQ-028 Reset mid-transfer SHALL abandon the command with no status emitted.

Verification
REQ-029 BTT=0x80, SADDR=0x1000, TAG=5, EOF=1, slave OKAY -> one burst ARADDR=0x1000, ARLEN=15; 16 beats, TLAST on beat 16; status 0x85.
REQ-030 BTT=0x100, SADDR=0x0FC0 -> bursts 0x0FC0 ARLEN=7, 0x1000 ARLEN=15, 0x1080 ARLEN=7; 32 beats total.
REQ-031 BTT=0x0C -> no ARVALID; status TAG|0x10.
REQ-032 BTT=0x40, TAG=2, beat 3 RRESP=2'b10 -> all 8 beats forwarded; status 0x42.
REQ-033 Random TREADY/RVALID/ARREADY/STS_TREADY stalls -> data order preserved, no beat lost or duplicated, AR and STS signals stable while stalled.
REQ-034 aresetn pulsed low during beat 4 of a 16-beat burst -> all valids 0 asynchronously; no status emitted; next command completes normally.
